namuru_time_base: RTL and testbench
===================================

# namuru_time_base

Sample-rate time base for the Namuru GPS correlator. Consumes the divider values (`tic_divide`, `accum_divide`) and soft reset (`rstn`) programmed through the Namuru CSR interface. Produces the TIC and accumulation-interrupt strobes, plus the sample enable, that drive the tracking channels. Also returns live counter values for CSR readback.

## Interface
Parameters:
- `DIV_W`, 24, width of divider values and counters

Ports:
- `sys_clk`  in  1  system clock
- `sys_rst`  in  1  synchronous, active-high reset
- `rstn`  in  1  soft reset from CSR block, active low
- `sample_strobe`  in  1  one-cycle pulse per front-end sample
- `tic_divide`  in  DIV_W  TIC period minus one, in samples
- `accum_divide`  in  DIV_W  accumulation period minus one, in samples
- `accum_sample_enable`  out  1  registered copy of `sample_strobe`, gated by `rstn`
- `pre_tic_enable`  out  1  one-cycle pulse at TIC counter reload
- `tic_enable`  out  1  one-cycle pulse one sample after `pre_tic_enable`
- `accum_enable`  out  1  one-cycle pulse at accumulation counter reload
- `tic_count`  out  DIV_W  current TIC down-counter value
- `accum_count`  out  DIV_W  current accumulation down-counter value

## Operation
- All outputs are registered. Every output resets to 0 on `sys_rst`.
- When `rstn`=0 and `sys_rst`=0:
  - `tic_count` loads `tic_divide` every cycle; `accum_count` loads `accum_divide` every cycle.
  - All enables are held at 0.
  - A pending `tic_enable` is cancelled.
- When `rstn`=1, each counter acts only on a cycle where `sample_strobe`=1:
  - If the count is 0: reload the divide value and pulse the associated enable (`pre_tic_enable` / `accum_enable`).
  - Otherwise: decrement by 1.
  - Period is therefore divide+1 samples.
  - A divide value of 0 gives a pulse on every sample.
- Divide values are sampled only at reload. A mid-period change takes effect from the next period. The current period is not disturbed.
- `tic_enable` handling:
  - A pending flag is set together with `pre_tic_enable`.
  - On the next `sample_strobe` cycle, `tic_enable` pulses and the flag clears.
  - If that same strobe also reloads the TIC counter (divide=0), the flag is set again. This gives `pre_tic_enable` and `tic_enable` in the same cycle.
- The TIC and accum counters are independent. When both reload on the same strobe, both pulse in the same cycle.
- After `sys_rst` with `rstn`=1, counters are 0, so the first strobe produces a reload pulse immediately.

## Timing
- `sample_strobe` high at cycle n:
  - `accum_sample_enable` is high at n+1.
  - Any reload pulse is high at n+1.
  - The updated counts are visible at n+1.
- Each enable is high for exactly one `sys_clk` cycle, regardless of strobe spacing.
- `tic_enable` goes high one cycle after the first strobe that follows the `pre_tic_enable` strobe.
- `sample_strobe` held high continuously means one sample per clock. The pipeline sustains this with no bubbles.
- `rstn` deassertion at cycle k: the first strobe at or after k decrements from the loaded divide value. No pulse occurs earlier than divide+1 strobes.
- `sys_rst` has priority over `rstn` and `sample_strobe`.

## Structure
- Shared Namuru package holds `DIV_W`=24 and the divider type.
- One sub-module, `namuru_divider`, is instantiated twice (TIC, accum). It contains a reloadable down-counter with hold-load, strobe, divide and count ports, plus a reload pulse output.
- The top level adds the `tic_enable` pending flag and the `accum_sample_enable` register.

## Test plan
- Reset and defaults: `sys_rst` for 3 cycles -> all outputs 0. Then `rstn`=0 with `tic_divide`=5 -> `tic_count`=5, no enables.
- Basic period: `rstn`=1, strobe every cycle, `tic_divide`=3, `accum_divide`=1 -> `pre_tic_enable` every 4 cycles, `tic_enable` exactly 1 cycle later, `accum_enable` every 2 cycles. Coincident pulses are checked at every multiple of 4.
- Sparse strobes: strobe every 3rd cycle, `tic_divide`=2 -> `pre_tic_enable` every 9 cycles; `tic_enable` 3 cycles after it; every pulse one cycle wide.
- Divide=0: `tic_divide`=0, strobe every cycle -> `pre_tic_enable` and `tic_enable` high on every cycle after the first.
- Mid-period change: `tic_divide`=9, change to 2 when `tic_count`=6 -> the current period finishes with 10 samples, then 3-sample periods follow.
- Soft reset mid-operation: `rstn`=0 for 1 cycle between `pre_tic_enable` and the next strobe -> `tic_enable` is suppressed and `tic_count` reloads to `tic_divide`.

Source files
------------

// File: rtl/namuru_time_base_pkg.sv
// Shared definitions for the Namuru sample-rate time base.
// Holds the default divider/counter width and the matching divider type.
package namuru_time_base_pkg;

   localparam int NAMURU_DIV_W = 24;

   typedef logic [NAMURU_DIV_W-1:0] div_t;

endpackage

// File: rtl/namuru_divider.sv
// Reloadable down-counter used for both the TIC and accumulation periods.
//   clk_i        system clock
//   rst_i        synchronous active-high reset (count and pulse to 0)
//   hold_load_i  while high, the counter tracks divide_i and never pulses
//   strobe_i     one-cycle sample strobe; the counter only moves on these
//   divide_i     period minus one, sampled only at reload or hold-load
//   count_o      current down-counter value
//   reload_o     one-cycle pulse the cycle after a reload strobe
module namuru_divider
   import namuru_time_base_pkg::*;
#(
   parameter int W = NAMURU_DIV_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         hold_load_i,
   input  logic         strobe_i,
   input  logic [W-1:0] divide_i,
   output logic [W-1:0] count_o,
   output logic         reload_o
);

   logic [W-1:0] count_q, count_d;
   logic         reload_q, reload_d;

   always_comb begin
      count_d  = count_q;
      reload_d = 1'b0;
      if (hold_load_i) begin
         count_d = divide_i;
      end else if (strobe_i) begin
         // Reaching zero ends the period: a new divide value is picked up
         // only here, so mid-period changes never disturb the current one.
         if (count_q == '0) begin
            count_d  = divide_i;
            reload_d = 1'b1;
         end else begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q  <= '0;
         reload_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   assign count_o  = count_q;
   assign reload_o = reload_q;

endmodule

// File: rtl/namuru_time_base.sv
// Sample-rate time base for the Namuru GPS correlator.
// Divides the front-end sample strobe into TIC and accumulation periods.
//   sys_clk / sys_rst      clock and synchronous active-high reset
//   rstn                   soft reset, active low: counters track the divide
//                          values, all enables held low, pending TIC dropped
//   sample_strobe          one-cycle pulse per front-end sample
//   tic_divide             TIC period minus one, in samples
//   accum_divide           accumulation period minus one, in samples
//   accum_sample_enable    registered sample_strobe gated by rstn
//   pre_tic_enable         pulse at TIC counter reload
//   tic_enable             pulse one sample after pre_tic_enable
//   accum_enable           pulse at accumulation counter reload
//   tic_count, accum_count live counter values for readback
// Strobe semantics: sample_strobe is a qualifier with no back-pressure; a
// strobe at cycle n is reflected in every output at n+1, and strobes may
// arrive on consecutive cycles.
module namuru_time_base
   import namuru_time_base_pkg::*;
#(
   parameter int DIV_W = NAMURU_DIV_W
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             rstn,
   input  logic             sample_strobe,
   input  logic [DIV_W-1:0] tic_divide,
   input  logic [DIV_W-1:0] accum_divide,
   output logic             accum_sample_enable,
   output logic             pre_tic_enable,
   output logic             tic_enable,
   output logic             accum_enable,
   output logic [DIV_W-1:0] tic_count,
   output logic [DIV_W-1:0] accum_count
);

   logic hold_load;
   logic strobe_run;
   logic pending_q, pending_d;
   logic tic_en_q, tic_en_d;
   logic ase_q, ase_d;
   logic pending_now;

   assign hold_load  = ~rstn;
   assign strobe_run = rstn & sample_strobe;

   namuru_divider #(.W(DIV_W)) u_tic_div (
      .clk_i       (sys_clk),
      .rst_i       (sys_rst),
      .hold_load_i (hold_load),
      .strobe_i    (strobe_run),
      .divide_i    (tic_divide),
      .count_o     (tic_count),
      .reload_o    (pre_tic_enable)
   );

   namuru_divider #(.W(DIV_W)) u_accum_div (
      .clk_i       (sys_clk),
      .rst_i       (sys_rst),
      .hold_load_i (hold_load),
      .strobe_i    (strobe_run),
      .divide_i    (accum_divide),
      .count_o     (accum_count),
      .reload_o    (accum_enable)
   );

   // A TIC is owed from the cycle pre_tic_enable is high until the next
   // strobe. Folding the live pre_tic_enable in lets back-to-back strobes
   // (and divide=0) produce tic_enable without a bubble; a reload on that
   // same strobe re-arms through pre_tic_enable on the following cycle.
   assign pending_now = pending_q | pre_tic_enable;

   always_comb begin
      pending_d = pending_now;
      tic_en_d  = 1'b0;
      ase_d     = strobe_run;
      if (!rstn) begin
         pending_d = 1'b0;
      end else if (sample_strobe) begin
         tic_en_d  = pending_now;
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pending_q <= 1'b0;
         tic_en_q  <= 1'b0;
         ase_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         tic_en_q  <= tic_en_d;
         ase_q     <= ase_d;
      end
   end

   assign tic_enable          = tic_en_q;
   assign accum_sample_enable = ase_q;

endmodule

// File: tb/tb_namuru_time_base.sv
module tb_namuru_time_base;

  localparam int W = 24;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         sys_rst;
  logic         rstn;
  logic         sample_strobe;
  logic [W-1:0] tic_divide;
  logic [W-1:0] accum_divide;
  logic         accum_sample_enable;
  logic         pre_tic_enable;
  logic         tic_enable;
  logic         accum_enable;
  logic [W-1:0] tic_count;
  logic [W-1:0] accum_count;

  namuru_time_base #(.DIV_W(W)) dut (
    .sys_clk             (clk),
    .sys_rst             (sys_rst),
    .rstn                (rstn),
    .sample_strobe       (sample_strobe),
    .tic_divide          (tic_divide),
    .accum_divide        (accum_divide),
    .accum_sample_enable (accum_sample_enable),
    .pre_tic_enable      (pre_tic_enable),
    .tic_enable          (tic_enable),
    .accum_enable        (accum_enable),
    .tic_count           (tic_count),
    .accum_count         (accum_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each channel is described as "a period of per samples,
  // of which seen have elapsed"; the count shown is the samples still to go.
  int  m_tic_per, m_tic_seen, m_acc_per, m_acc_seen;
  bit  m_tic_owed;
  bit  e_ase, e_pre, e_tic, e_acc;
  int  e_tic_cnt, e_acc_cnt;

  function automatic int model_tic_count();
    return m_tic_per - 1 - m_tic_seen;
  endfunction

  function automatic int model_acc_count();
    return m_acc_per - 1 - m_acc_seen;
  endfunction

  task automatic model_step(input bit sr, input bit rn, input bit st,
                            input int tdiv, input int adiv);
    e_ase = 0; e_pre = 0; e_tic = 0; e_acc = 0;
    if (sr) begin
      m_tic_per = 1; m_tic_seen = 0;
      m_acc_per = 1; m_acc_seen = 0;
      m_tic_owed = 0;
    end else if (!rn) begin
      m_tic_per = tdiv + 1; m_tic_seen = 0;
      m_acc_per = adiv + 1; m_acc_seen = 0;
      m_tic_owed = 0;
    end else if (st) begin
      e_ase = 1;
      if (m_tic_owed) begin
        e_tic = 1;
        m_tic_owed = 0;
      end
      m_tic_seen++;
      if (m_tic_seen == m_tic_per) begin
        e_pre = 1;
        m_tic_owed = 1;
        m_tic_per = tdiv + 1;
        m_tic_seen = 0;
      end
      m_acc_seen++;
      if (m_acc_seen == m_acc_per) begin
        e_acc = 1;
        m_acc_per = adiv + 1;
        m_acc_seen = 0;
      end
    end
    e_tic_cnt = model_tic_count();
    e_acc_cnt = model_acc_count();
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // driver: apply one cycle of inputs, advance, and check every output
  task automatic step(input bit sr, input bit rn, input bit st);
    @(negedge clk);
    sys_rst = sr; rstn = rn; sample_strobe = st;
    model_step(sr, rn, st, int'(tic_divide), int'(accum_divide));
    @(posedge clk);
    #1;
    chk("accum_sample_enable", {31'd0, accum_sample_enable}, {31'd0, e_ase});
    chk("pre_tic_enable",      {31'd0, pre_tic_enable},      {31'd0, e_pre});
    chk("tic_enable",          {31'd0, tic_enable},          {31'd0, e_tic});
    chk("accum_enable",        {31'd0, accum_enable},        {31'd0, e_acc});
    chk("tic_count",           {8'd0, tic_count},            32'(e_tic_cnt));
    chk("accum_count",         {8'd0, accum_count},          32'(e_acc_cnt));
  endtask

  initial begin
    bit seen_pre;
    int guard;
    sys_rst = 1'b1; rstn = 1'b0; sample_strobe = 1'b0;
    tic_divide = '0; accum_divide = '0;
    m_tic_per = 1; m_tic_seen = 0; m_acc_per = 1; m_acc_seen = 0; m_tic_owed = 0;

    // reset and defaults (sys_rst wins over rstn and strobe)
    step(1, 0, 0);
    step(1, 1, 1);
    step(1, 1, 1);
    tic_divide = 24'd5; accum_divide = 24'd2;
    step(0, 0, 0);
    step(0, 0, 1);
    chk("soft_reset_tic_count", {8'd0, tic_count}, 32'd5);

    // basic period: tic 3, accum 1, strobe every cycle
    tic_divide = 24'd3; accum_divide = 24'd1;
    step(0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 1);

    // sparse strobes every 3rd cycle, tic 2
    tic_divide = 24'd2;
    step(0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 1, (i % 3) == 0);

    // divide 0: pulse every sample
    tic_divide = 24'd0; accum_divide = 24'd0;
    step(0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1);
    chk("div0_tic_enable", {31'd0, tic_enable}, 32'd1);

    // mid-period change from 9 to 2 once tic_count reads 6
    tic_divide = 24'd9; accum_divide = 24'd4;
    step(0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      if (model_tic_count() == 6 && tic_divide == 24'd9) tic_divide = 24'd2;
      step(0, 1, 1);
    end

    // soft reset between pre_tic_enable and the next strobe
    tic_divide = 24'd3;
    step(0, 0, 0);
    seen_pre = 0;
    guard = 0;
    while (!seen_pre && guard < 40) begin
      step(0, 1, (guard % 2) == 0);
      seen_pre = e_pre;
      guard++;
    end
    chk("pre_tic_seen_before_soft_reset", {31'd0, seen_pre}, 32'd1);
    step(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, (i % 2) == 0);
      if (i < 2) chk("tic_suppressed", {31'd0, tic_enable}, 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) tic_divide   = W'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) accum_divide = W'($urandom_range(0, 5));
      step($urandom_range(0, 99) < 2, $urandom_range(0, 24) != 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
